sa_feeder: RTL
==============

SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 Parameter: size, 10, element width of A/B matrix entries and of each skewed output stream.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: wr_en  input  1  matrix-buffer write strobe.
REQ-005 Port: wr_sel  input  1  0 = write matrix A, 1 = write matrix B.
REQ-006 Port: wr_row  input  2  row index of entry written.
REQ-007 Port: wr_col  input  2  column index of entry written.
REQ-008 Port: wr_data  input  size  entry value, unsigned.
REQ-009 Port: start  input  1  begin one 4x4 product sequence.
REQ-010 Port: busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-011 Port: done  output  1  one-cycle pulse; systolic array results final during this cycle.
REQ-012 Port: sa_reset  output  1  synchronous clear for the downstream 4x4 systolic array.
REQ-013 Port: a1..a4  output  size each  row streams, a(i+1) feeds array row i.
REQ-014 Port: b1..b4  output  size each  column streams, b(j+1) feeds array column j.

Function
REQ-015 All outputs SHALL be registered; FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-016 IDLE: wr_en=1 SHALL write wr_data to A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1) at the edge.
REQ-017 wr_en while busy SHALL be ignored; buffer contents unchanged.
REQ-018 IDLE with start=1 SHALL move to CLEAR; a write on the same edge SHALL take effect and be used by that run.
REQ-019 start while busy SHALL be ignored.
REQ-020 CLEAR (1 cycle): sa_reset=1, all a/b = 0.
REQ-021 FEED (7 cycles, step k=0..6): a(i+1) = A[i][k-i] when 0<=k-i<=3 else 0; b(j+1) = B[k-j][j] when 0<=k-j<=3 else 0; sa_reset=0.
REQ-022 DRAIN (3 cycles): all a/b = 0, sa_reset=0.
REQ-023 DONE (1 cycle): done=1, busy=1, a/b = 0; next state IDLE.
REQ-024 Latency: start sampled at edge E0 -> CLEAR in cycle 1, FEED cycles 2-8, DRAIN cycles 9-11, done in cycle 12.
REQ-025 IDLE: sa_reset=0, a/b = 0, so the array holds its results until the next run.
REQ-026 Downstream output c(4r+c+1) SHALL equal sum over k of A[r][k]*B[k][c] during done; the feeder performs no arithmetic and handles no overflow.
REQ-027 Buffer contents SHALL persist across runs; back-to-back runs without rewriting reuse prior data.

Reset
REQ-028 reset=1 SHALL asynchronously force state IDLE, busy=0, done=0, sa_reset=1, a/b = 0, and all A/B entries to 0.
REQ-029 Reset mid-run SHALL abort the sequence with no done pulse; the first cycle after release SHALL be IDLE with sa_reset=0.

Structure
REQ-030 Shared package sa_pkg SHALL hold SIZE=10, N=4, FEED_CYCLES=7, DRAIN_CYCLES=3 and the FSM state enum.
REQ-031 One sub-module sa_matrix_buf (4x4 size-bit register file, one write port, 16 parallel read outputs) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-032 A=identity, B[r][c]=4r+c+1, start -> done in cycle 12; downstream c1..c16 = 1..16.
REQ-033 A[i][k]=10i+k+1, B=0 -> a3 over FEED steps 0..6 = 0,0,21,22,23,24,0; a1 = 1,2,3,4,0,0,0.
REQ-034 A=B=all 511 -> every c = 1044484; sa_reset high only in cycle 1.
REQ-035 start and wr_en(A[0][0]=99) pulsed in cycle 5 of a run -> no restart, done still in cycle 12, A[0][0] unchanged on the next run.
REQ-036 reset asserted in FEED step 3 -> a/b immediately 0, sa_reset=1, busy=0, no done; a new start with no reload -> all c = 0.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants and FSM state encoding for the systolic-array feeder.
package sa_pkg;
    localparam int SIZE         = 10;
    localparam int N            = 4;
    localparam int FEED_CYCLES  = 7;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/sa_matrix_buf.sv
// 4x4 register file: one write port, every entry readable in parallel.
module sa_matrix_buf
    import sa_pkg::*;
#(
    parameter int width = SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [1:0]       wr_row,
    input  logic [1:0]       wr_col,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] q [N][N]
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic [width-1:0] entry_reg;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        entry_reg <= '0;
                    end else if (wr_en && wr_row == 2'(gi) && wr_col == 2'(gj)) begin
                        entry_reg <= wr_data;
                    end
                end

                assign q[gi][gj] = entry_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/sa_feeder.sv
// Holds A and B operands and streams them, skewed, into a 4x4 output-stationary
// systolic array: one clear cycle, seven feed steps, three drain cycles, done.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int size = SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [1:0]      wr_row,
    input  logic [1:0]      wr_col,
    input  logic [size-1:0] wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            sa_reset,
    output logic [size-1:0] a1,
    output logic [size-1:0] a2,
    output logic [size-1:0] a3,
    output logic [size-1:0] a4,
    output logic [size-1:0] b1,
    output logic [size-1:0] b2,
    output logic [size-1:0] b3,
    output logic [size-1:0] b4
);

    localparam logic [2:0] LAST_FEED  = 3'(FEED_CYCLES - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(DRAIN_CYCLES - 1);

    state_t          state_reg;
    logic [2:0]      step_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            sa_reset_reg;
    logic [size-1:0] a_reg [N];
    logic [size-1:0] b_reg [N];

    logic [size-1:0] a_q [N][N];
    logic [size-1:0] b_q [N][N];
    logic [size-1:0] feed_a [N];
    logic [size-1:0] feed_b [N];
    logic [2:0]      feed_step;
    logic            buf_wr;

    // The buffers are only writable while idle, so a run always sees a stable operand set.
    assign buf_wr = wr_en && (state_reg == IDLE);

    sa_matrix_buf #(.width(size)) u_buf_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr && !wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .q       (a_q)
    );

    sa_matrix_buf #(.width(size)) u_buf_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr && wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .q       (b_q)
    );

    // Step that the output registers will present in the coming cycle.
    assign feed_step = (state_reg == CLEAR) ? 3'd0 : step_reg + 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_feed
            logic [3:0] diff;
            logic       in_window;

            // Negative offsets wrap to large values, so one range test covers both ends.
            assign diff      = {1'b0, feed_step} - 4'(gi);
            assign in_window = (diff[3:2] == 2'b00);
            assign feed_a[gi] = in_window ? a_q[gi][diff[1:0]] : '0;
            assign feed_b[gi] = in_window ? b_q[diff[1:0]][gi] : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            step_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sa_reset_reg <= 1'b1;
            for (int i = 0; i < N; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            done_reg     <= 1'b0;
            sa_reset_reg <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    if (start) begin
                        state_reg    <= CLEAR;
                        busy_reg     <= 1'b1;
                        sa_reset_reg <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_reg <= FEED;
                    step_reg  <= '0;
                    for (int i = 0; i < N; i++) begin
                        a_reg[i] <= feed_a[i];
                        b_reg[i] <= feed_b[i];
                    end
                end
                FEED: begin
                    if (step_reg == LAST_FEED) begin
                        state_reg <= DRAIN;
                        step_reg  <= '0;
                    end else begin
                        step_reg <= step_reg + 3'd1;
                        for (int i = 0; i < N; i++) begin
                            a_reg[i] <= feed_a[i];
                            b_reg[i] <= feed_b[i];
                        end
                    end
                end
                DRAIN: begin
                    if (step_reg == LAST_DRAIN) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        step_reg <= step_reg + 3'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sa_reset = sa_reset_reg;
    assign a1 = a_reg[0];
    assign a2 = a_reg[1];
    assign a3 = a_reg[2];
    assign a4 = a_reg[3];
    assign b1 = b_reg[0];
    assign b2 = b_reg[1];
    assign b3 = b_reg[2];
    assign b4 = b_reg[3];

endmodule
